// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register, writeback mux, zero-register write suppression and retire counter.
// Optional sub-word load extraction is enabled by defining WB_SUBWORD_LOAD_EN.
module wb_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     ALUOut,
    input  logic [DATA_W-1:0]     MemoryOut,
    input  logic [CTRL_W-1:0]     Controls,
    input  logic [REG_ADDR_W-1:0] writeReg_in,
    output logic [DATA_W-1:0]     writeBackData,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic                  wb_valid,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    logic                  valid_q;
    logic [DATA_W-1:0]     alu_q;
    logic [DATA_W-1:0]     mem_q;
    logic [CTRL_W-1:0]     ctrl_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     load_data;
    logic                  unused_ctrl;

    // Handshake: in_valid qualifies the inputs; stall acts as "not ready", so an
    // entry is accepted and the held one retires only on an edge with stall=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            mem_q   <= '0;
            ctrl_q  <= '0;
            addr_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= in_valid;
            alu_q   <= ALUOut;
            mem_q   <= MemoryOut;
            ctrl_q  <= Controls;
            addr_q  <= writeReg_in;
        end
    end

    // The held instruction is counted once, on the edge that moves it out.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (valid_q && !stall && !flush) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] half_off;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    always_comb begin
        off      = alu_q[OFF_W-1:0];
        half_off = {off[OFF_W-1:1], 1'b0};
        byte_sel = 8'(mem_q >> {off, 3'b000});
        half_sel = 16'(mem_q >> {half_off, 3'b000});
        load_data = mem_q;
        case (ctrl_q[22:21])
            2'b01:   load_data = ctrl_q[23] ? DATA_W'(byte_sel)
                                            : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            2'b10:   load_data = ctrl_q[23] ? DATA_W'(half_sel)
                                            : {{(DATA_W-16){half_sel[15]}}, half_sel};
            default: load_data = mem_q;
        endcase
    end
`else
    always_comb begin
        load_data = mem_q;
    end
`endif

    // Only a handful of control bits matter in this stage; the rest ride along.
    assign unused_ctrl = ^ctrl_q;

    assign writeBackData = ctrl_q[20] ? load_data : alu_q;
    assign regWrite      = valid_q & ctrl_q[19] & (addr_q != '0);
    assign writeReg      = addr_q;
    assign wb_valid      = valid_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe: driver pushes expected outputs from a
// transaction-level model, a monitor pops and compares one cycle later.
module tb_wb_stage_pipe;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 32;
    localparam int RA_W   = 5;
    localparam int CNT_W  = 4;
    localparam int W      = DATA_W + 1 + RA_W + 1 + CNT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] ALUOut = '0;
    logic [DATA_W-1:0] MemoryOut = '0;
    logic [CTRL_W-1:0] Controls = '0;
    logic [RA_W-1:0]   writeReg_in = '0;
    logic [DATA_W-1:0] writeBackData;
    logic              regWrite;
    logic [RA_W-1:0]   writeReg;
    logic              wb_valid;
    logic [CNT_W-1:0]  retire_cnt;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    wb_stage_pipe #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_ADDR_W(RA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .ALUOut(ALUOut), .MemoryOut(MemoryOut), .Controls(Controls),
        .writeReg_in(writeReg_in), .writeBackData(writeBackData),
        .regWrite(regWrite), .writeReg(writeReg), .wb_valid(wb_valid),
        .retire_cnt(retire_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: the instruction currently held in the stage
    logic        m_valid = 1'b0;
    logic [31:0] m_alu = '0, m_mem = '0, m_ctrl = '0;
    logic [4:0]  m_addr = '0;
    int          m_retired = 0;

    function automatic logic [31:0] ref_load(input logic [31:0] mem, alu, ctrl);
`ifdef WB_SUBWORD_LOAD_EN
        longint unsigned m = mem;
        longint unsigned off = alu % 4;
        longint unsigned v = m;
        if (ctrl[22:21] == 2'b01) begin
            v = (m >> (8 * off)) % 256;
            if (!ctrl[23] && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (ctrl[22:21] == 2'b10) begin
            v = (m >> (8 * (off - off % 2))) % 65536;
            if (!ctrl[23] && v >= 32768) v = v + 64'hFFFF_0000;
        end
        return v[31:0];
`else
        return mem;
`endif
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [31:0] d;
        logic        w;
        d = m_ctrl[20] ? ref_load(m_mem, m_alu, m_ctrl) : m_alu;
        w = m_valid && m_ctrl[19] && (m_addr != 0);
        return {d, w, m_addr, m_valid, CNT_W'(m_retired)};
    endfunction

    // driver: one call = one clock edge of stimulus plus its expected result
    task automatic step(input logic r, v, s, f, input logic [31:0] alu, mem, ctrl,
                        input logic [4:0] addr);
        @(negedge clk);
        rst = r; in_valid = v; stall = s; flush = f;
        ALUOut = alu; MemoryOut = mem; Controls = ctrl; writeReg_in = addr;
        if (r) begin
            m_valid = 0; m_alu = 0; m_mem = 0; m_ctrl = 0; m_addr = 0; m_retired = 0;
        end else if (f) begin
            m_valid = 0;
        end else if (!s) begin
            if (m_valid) m_retired++;
            m_valid = v; m_alu = alu; m_mem = mem; m_ctrl = ctrl; m_addr = addr;
        end
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input logic r, s, f);
        step(r, 1'b0, s, f, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
    endtask

    // monitor / scoreboard: the stage presents a result every cycle
    always @(posedge clk) begin
        logic [W-1:0] got, exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {writeBackData, regWrite, writeReg, wb_valid, retire_cnt};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wb_out @%0t: got data=%h rw=%b reg=%0d v=%b cnt=%0d, want data=%h rw=%b reg=%0d v=%b cnt=%0d",
                         $time, got[W-1 -: 32], got[W-33], got[W-34 -: 5], got[CNT_W], got[CNT_W-1:0],
                         exp[W-1 -: 32], exp[W-33], exp[W-34 -: 5], exp[CNT_W], exp[CNT_W-1:0]);
            end
        end
    end

    localparam logic [31:0] C_MEM2REG = 32'h0010_0000;
    localparam logic [31:0] C_REGWR   = 32'h0008_0000;

    initial begin
        int wait_cycles;
        logic [31:0] ld_ctrl;
        // reset state
        idle(1, 0, 0);
        idle(1, 1, 1);
        // ALU writeback, then load to r0 (suppressed)
        step(0, 1, 0, 0, 32'h0000_1234, $urandom, C_REGWR, 5'd5);
        step(0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF, C_MEM2REG | C_REGWR, 5'd0);
        // valid entry held across a 3-cycle stall, then released
        step(0, 1, 0, 0, 32'h0000_0ABC, $urandom, C_REGWR, 5'd9);
        repeat (3) step(0, 1, 1, 0, $urandom, $urandom, $urandom, 5'd7);
        idle(0, 0, 0);
        // stall+flush together on a valid entry, then reset mid-stream
        step(0, 1, 0, 0, 32'h5555_0001, $urandom, C_REGWR, 5'd3);
        step(0, 1, 1, 1, $urandom, $urandom, C_REGWR, 5'd4);
        step(0, 1, 0, 0, 32'h6666_0002, $urandom, C_REGWR, 5'd6);
        idle(1, 1, 1);
        // 17 back-to-back retirements wrap the 4-bit counter
        repeat (17) step(0, 1, 0, 0, $urandom, $urandom, C_REGWR, 5'($urandom_range(1, 31)));
        idle(0, 0, 0);
        // sub-word loads of 0x80F17F02: {size, unsigned, offset}
        for (int i = 0; i < 8; i++) begin
            ld_ctrl = C_MEM2REG | C_REGWR | (32'(i % 4 == 3 ? 2 : 1) << 21) | (32'(i % 2) << 23);
            step(0, 1, 0, 0, 32'(i / 2), 32'h80F1_7F02, ld_ctrl, 5'd12);
        end
        step(0, 1, 0, 0, 32'h2, 32'h80F1_7F02, C_MEM2REG | C_REGWR | (32'd2 << 21), 5'd13);
        step(0, 1, 0, 0, 32'h3, 32'h80F1_7F02, C_MEM2REG | C_REGWR | (32'd3 << 21), 5'd14);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
        end
        idle(0, 0, 0);
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected results left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
